// File: rtl/spike_injector_obi.sv
// OBI-slave spike source: unpacks CPU-written neuron indices into the event FIFO
// one per cycle and pulses spikecore_done_o once a committed batch is fully pushed.

package spike_injector_obi_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_rsp_t;
endpackage

module spike_injector_obi
   import spike_injector_obi_pkg::*;
#(
   parameter int  M     = 8,
   parameter int  CNT_W = 16,
   parameter type req_t = obi_req_t,
   parameter type rsp_t = obi_rsp_t
) (
   input  logic         CLK,
   input  logic         RST,
   input  req_t         control_slave_req_i,
   output rsp_t         control_slave_resp_o,
   output logic         FIFO_w_en_o,
   output logic [M-1:0] FIFO_w_data_o,
   input  logic         FIFO_full_i,
   output logic         spikecore_done_o,
   output logic [1:0]   dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_stage;
   logic [3:0]        r_mask;
   logic              r_commit_pending;
   logic              r_done_flag;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rvalid;
   logic [31:0]       r_rdata;

   logic [1:0]        w_sel;
   logic              w_gnt;
   logic              w_data_wr;
   logic              w_ctrl_wr;
   logic              w_clear;
   logic              w_commit;
   logic              w_stat_rd;
   logic              w_busy;
   logic [31:0]       w_status;
   logic [1:0]        w_lane;
   logic [3:0]        w_lane_oh;
   logic [3:0]        w_mask_left;
   logic [7:0]        w_lane_byte;
   logic              w_push;
   logic              w_done;
   logic              w_unused;

   // OBI: a request completes on req && gnt; its response is rvalid one cycle later.
   // DATA writes hold off (gnt low) until every staged lane has been pushed.
   assign w_sel     = control_slave_req_i.addr[3:2];
   assign w_gnt     = RST & control_slave_req_i.req &
                      ~(control_slave_req_i.we & (w_sel == 2'd0) & (r_mask != 4'd0));
   assign w_data_wr = w_gnt & control_slave_req_i.we & (w_sel == 2'd0);
   assign w_ctrl_wr = w_gnt & control_slave_req_i.we & (w_sel == 2'd1);
   assign w_clear   = w_ctrl_wr & control_slave_req_i.wdata[1];
   assign w_commit  = w_ctrl_wr & control_slave_req_i.wdata[0] & ~control_slave_req_i.wdata[1];
   assign w_stat_rd = w_gnt & ~control_slave_req_i.we & (w_sel == 2'd2);
   assign w_busy    = (r_state != S_IDLE) | (r_mask != 4'd0);

   always_comb begin
      w_status                = '0;
      w_status[0]             = w_busy;
      w_status[1]             = r_done_flag;
      w_status[CNT_W+15:16]   = r_cnt;
   end

   // Lowest set lane is pushed first; the descending loop lets the lowest bit win.
   always_comb begin
      w_lane = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (r_mask[k]) w_lane = 2'(k);
      end
   end

   assign w_lane_oh   = 4'b0001 << w_lane;
   assign w_mask_left = r_mask & ~w_lane_oh;
   assign w_lane_byte = r_stage[{w_lane, 3'b000} +: 8];

   always_ff @(posedge CLK) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_data_wr && (control_slave_req_i.be != 4'd0)) w_state_nxt = S_DRAIN;
            else if (w_commit)                                 w_state_nxt = S_DONE;
         end
         S_DRAIN: begin
            w_push = ~FIFO_full_i & ~w_clear;
            if (w_clear) begin
               w_state_nxt = S_IDLE;
            end else if (w_push && (w_mask_left == 4'd0)) begin
               w_state_nxt = (r_commit_pending | w_commit) ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = (w_data_wr && (control_slave_req_i.be != 4'd0)) ? S_DRAIN : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_stage          <= '0;
         r_mask           <= '0;
         r_commit_pending <= 1'b0;
         r_done_flag      <= 1'b0;
         r_cnt            <= '0;
         r_rvalid         <= 1'b0;
         r_rdata          <= '0;
      end else begin
         r_rvalid <= w_gnt;
         r_rdata  <= w_stat_rd ? w_status : 32'd0;
         if (w_push) r_cnt <= r_cnt + CNT_W'(1);

         if (w_clear) begin
            r_mask <= '0;
         end else if (w_data_wr) begin
            r_mask  <= control_slave_req_i.be;
            r_stage <= control_slave_req_i.wdata;
         end else if (w_push) begin
            r_mask <= w_mask_left;
         end

         if (w_clear || (r_state == S_DONE))            r_commit_pending <= 1'b0;
         else if (w_commit && (r_state == S_DRAIN))     r_commit_pending <= 1'b1;

         if (w_clear || w_data_wr)    r_done_flag <= 1'b0;
         else if (r_state == S_DONE)  r_done_flag <= 1'b1;
      end
   end

   always_comb begin
      control_slave_resp_o        = '0;
      control_slave_resp_o.gnt    = w_gnt;
      control_slave_resp_o.rvalid = RST & r_rvalid;
      control_slave_resp_o.rdata  = RST ? r_rdata : 32'd0;
   end

   assign FIFO_w_en_o      = RST & w_push;
   assign FIFO_w_data_o    = (RST && (r_state == S_DRAIN)) ? w_lane_byte[M-1:0] : '0;
   assign spikecore_done_o = RST & w_done;
   assign dbg_state_o      = r_state;

   assign w_unused = ^{control_slave_req_i.addr[31:4], control_slave_req_i.addr[1:0], w_lane_byte};

endmodule
